echo_indication_output: RTL

ECHO_INDICATION_OUTPUT -- requirements
Module: echo_indication_output

---
 rtl/echo_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/echo_indication_output.sv | 58 +++++
 3 files changed

// File: rtl/echo_pkg.sv
// Types shared between the inbound dispatcher and the echo indication output path.
package echo_pkg;

    localparam logic [31:0] TAG_HEARD = 32'd1;

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] meth;
        logic [31:0] v;
    } EchoIndication_data;

    function automatic EchoIndication_data pack_heard(input logic [31:0] meth,
                                                      input logic [31:0] v);
        EchoIndication_data d;
        d.tag  = TAG_HEARD;
        d.meth = meth;
        d.v    = v;
        return d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy; head output holds the last popped word when empty.
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic             do_enq;
    logic             do_deq;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;
    assign dout   = empty ? last : mem[rd_ptr];

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + AW'(1);
            if (do_deq) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_enq) - (AW+1)'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= din;
    end

    // Reset keeps the empty-state output free of X before the first pop.
    always_ff @(posedge clk) begin
        if (rst)         last <= '0;
        else if (do_deq) last <= mem[rd_ptr];
    end

endmodule

// File: rtl/echo_indication_output.sv
// Buffers heard indications and forwards them, tagged, to the outbound pipe.
module echo_indication_output
    import echo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             heard__ENA,
    input  logic [31:0]      heard_meth,
    input  logic [31:0]      heard_v,
    output logic             heard__RDY,
    output logic             pipe_enq__ENA,
    output logic [95:0]      pipe_enq_v,
    input  logic             pipe_enq__RDY,
    output logic [CNT_W-1:0] sent_count,
    output logic             protocol_err
);

    logic               full;
    logic               empty;
    logic               accept;
    logic               deliver;
    EchoIndication_data packed_in;

    // Ready depends only on registered occupancy, never on pipe_enq__RDY.
    assign heard__RDY    = !full && !RST;
    assign pipe_enq__ENA = !empty && !RST;
    assign accept        = heard__ENA && heard__RDY;
    assign deliver       = pipe_enq__ENA && pipe_enq__RDY;
    assign packed_in     = pack_heard(heard_meth, heard_v);

    sync_fifo #(
        .WIDTH (96),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .enq   (accept),
        .deq   (deliver),
        .din   (packed_in),
        .dout  (pipe_enq_v),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK) begin
        if (RST)          sent_count <= '0;
        else if (deliver) sent_count <= sent_count + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST)                             protocol_err <= 1'b0;
        else if (heard__ENA && !heard__RDY) protocol_err <= 1'b1;
    end

endmodule
